// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD adder control slice.
package bcd_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SUM_W   = 5;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned CORR    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SUM,
    S_CHECK,
    S_INC_C,
    S_PLUS6,
    S_INC_S,
    S_DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_classify.sv
// Flags a raw 5-bit digit sum that is not a valid BCD digit and needs the +6 fix-up.
module bcd_digit_classify
  import bcd_ctrl_pkg::*;
(
  input  logic [SUM_W-1:0] digit_i,
  output logic             needs_corr_c_o
);

  assign needs_corr_c_o = (digit_i > SUM_W'(BCD_MAX));

endmodule

// File: rtl/bcd_add_control.sv
// Sequencer for an N-digit BCD adder datapath: load, per-digit add, optional +6 fix-up.
// Optional counter cross-check of s_i against idx_o is enabled by BCD_CTRL_CHECK_EN.
module bcd_add_control
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SUM_W-1:0]   digit_i,
  input  logic [DIGIT_W-1:0] s_i,
  output logic               state_load,
  output logic               state_sum,
  output logic               state_inc_c,
  output logic               state_plus_6_c,
  output logic               state_inc_s,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   idx_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic               err_q, err_d;
  logic               needs_corr;
  logic               s_mismatch;

  bcd_digit_classify u_classify (
    .digit_i        (digit_i),
    .needs_corr_c_o (needs_corr)
  );

`ifdef BCD_CTRL_CHECK_EN
  assign s_mismatch = (s_i != idx_q);
`else
  logic unused_s;
  assign unused_s   = ^s_i;
  assign s_mismatch = 1'b0;
`endif

  assign idx_inc = idx_q + IDX_W'(1);

  // Next-state, digit index and sticky error update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_SUM;
      end
      S_SUM:   state_d = S_CHECK;
      S_CHECK: begin
        state_d = needs_corr ? S_INC_C : S_INC_S;
        if (s_mismatch) err_d = 1'b1;
      end
      S_INC_C: state_d = S_PLUS6;
      S_PLUS6: state_d = S_INC_S;
      S_INC_S: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == IDX_W'(N)) ? S_DONE : S_SUM;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each tracks its state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      err_q          <= 1'b0;
      state_load     <= 1'b0;
      state_sum      <= 1'b0;
      state_inc_c    <= 1'b0;
      state_plus_6_c <= 1'b0;
      state_inc_s    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      err_q          <= err_d;
      state_load     <= (state_d == S_LOAD);
      state_sum      <= (state_d == S_SUM);
      state_inc_c    <= (state_d == S_INC_C);
      state_plus_6_c <= (state_d == S_PLUS6);
      state_inc_s    <= (state_d == S_INC_S);
      busy           <= (state_d != S_IDLE);
      done           <= (state_d == S_DONE);
    end
  end

  assign idx_o = idx_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_bcd_add_control.sv
// Randomized bench for bcd_add_control against a timeline model built per accepted start.
module tb_bcd_add_control;

  localparam int unsigned N = 5;
  localparam int C_IDLE = 0, C_LOAD = 1, C_SUM = 2, C_CHECK = 3,
                 C_INC_C = 4, C_PLUS6 = 5, C_INC_S = 6, C_DONE = 7;
`ifdef BCD_CTRL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] digit_i;
  logic [3:0] s_i;
  logic       state_load, state_sum, state_inc_c, state_plus_6_c, state_inc_s;
  logic       busy, done, err_o;
  logic [3:0] idx_o;

  always #5 clk = ~clk;

  bcd_add_control #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .digit_i(digit_i), .s_i(s_i),
    .state_load(state_load), .state_sum(state_sum), .state_inc_c(state_inc_c),
    .state_plus_6_c(state_plus_6_c), .state_inc_s(state_inc_s),
    .busy(busy), .done(done), .idx_o(idx_o), .err_o(err_o)
  );

  // One expected cycle: phase, expected idx (-1 = don't care), digit to present in CHECK
  typedef struct { int code; int idx; int dig; } ent_t;
  ent_t q[$];

  int errors = 0, checks = 0;
  int idx_m = 0, err_m = 0;
  int cyc = 0, t0 = 0;
  int plan_mode = 3;
  bit start_req = 1'b0, inject = 1'b0;
  int cnt[8];
  int done_at = -1, last_done = -1, done_gap = -1, done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int plan_digit(input int k);
    if (plan_mode == -1) return int'($urandom_range(0, 31));
    if (plan_mode == -2) return (k == 2) ? 16 : 9;
    return plan_mode;
  endfunction

  // Whole run is known at accept: LOAD, per digit SUM CHECK [INC_C PLUS6] INC_S, DONE
  task automatic build_run();
    int d;
    q.push_back('{C_LOAD, -1, 0});
    for (int k = 0; k < int'(N); k++) begin
      d = plan_digit(k);
      q.push_back('{C_SUM, k, 0});
      q.push_back('{C_CHECK, k, d});
      if (d > 9) begin
        q.push_back('{C_INC_C, k, 0});
        q.push_back('{C_PLUS6, k, 0});
      end
      q.push_back('{C_INC_S, k, 0});
    end
    q.push_back('{C_DONE, int'(N), 0});
    idx_m = int'(N);
  endtask

  function automatic ent_t cur_ent();
    ent_t e;
    if (q.size() > 0) return q[0];
    e.code = C_IDLE; e.idx = idx_m; e.dig = 0;
    return e;
  endfunction

  // Compare at negedge, drive next inputs, then advance the model at posedge
  task automatic step();
    ent_t e;
    logic [6:0] actv, expv;
    @(negedge clk);
    e = cur_ent();
    actv = {state_load, state_sum, state_inc_c, state_plus_6_c, state_inc_s, busy, done};
    expv = {e.code == C_LOAD, e.code == C_SUM, e.code == C_INC_C, e.code == C_PLUS6,
            e.code == C_INC_S, e.code != C_IDLE, e.code == C_DONE};
    check("outputs", int'(actv), int'(expv));
    if (e.idx >= 0) check("idx_o", int'(idx_o), e.idx);
    check("err_o", int'(err_o), err_m);
    cnt[C_LOAD]  += int'(state_load);
    cnt[C_SUM]   += int'(state_sum);
    cnt[C_INC_C] += int'(state_inc_c);
    cnt[C_PLUS6] += int'(state_plus_6_c);
    cnt[C_INC_S] += int'(state_inc_s);
    if (done) begin
      done_cnt++;
      done_at = cyc - t0;
      if (last_done >= 0) done_gap = cyc - last_done;
      last_done = cyc;
    end
    start   = start_req;
    digit_i = (e.code == C_CHECK) ? 5'(e.dig) : 5'($urandom_range(0, 31));
    s_i     = (e.idx >= 0) ? 4'(e.idx) : 4'($urandom_range(0, 15));
    if (inject && e.code == C_CHECK && e.idx == 1) s_i = 4'(e.idx + 1);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      idx_m = 0;
      err_m = 0;
    end else begin
      if (CHK_EN && e.code == C_CHECK && int'(s_i) != e.idx) err_m = 1;
      if (q.size() > 0) void'(q.pop_front());
      else if (start) begin
        err_m = 0;
        build_run();
        t0 = cyc - 1;
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    done_at = -1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", int'(q.size() == 0), 1);
  endtask

  task automatic run_one(input int mode);
    clear_counts();
    plan_mode = mode;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    drain();
  endtask

  initial begin
    int n, dc0;
    int vals[6];
    rst = 1'b1; start = 1'b0; digit_i = '0; s_i = '0;
    repeat (2) step();
    check("reset_outputs",
          int'({state_load, state_sum, state_inc_c, state_plus_6_c, state_inc_s, busy, done, idx_o, err_o}), 0);
    rst = 1'b0;
    repeat (2) step();

    // All digits valid: no correction, done in 17th cycle
    run_one(3);
    check("n_load", cnt[C_LOAD], 1);
    check("n_sum", cnt[C_SUM], 5);
    check("n_inc_c", cnt[C_INC_C], 0);
    check("n_plus6", cnt[C_PLUS6], 0);
    check("n_inc_s", cnt[C_INC_S], 5);
    check("lat_nocorr", done_at, 17);

    // Every digit corrected: done in 27th cycle
    run_one(12);
    check("n_inc_c_12", cnt[C_INC_C], 5);
    check("n_plus6_12", cnt[C_PLUS6], 5);
    check("lat_corr", done_at, 27);

    // One 16 among nines
    run_one(-2);
    check("n_inc_c_16", cnt[C_INC_C], 1);
    check("n_plus6_16", cnt[C_PLUS6], 1);
    check("lat_mixed", done_at, 19);

    // Classification boundaries
    vals = '{0, 9, 10, 15, 16, 31};
    foreach (vals[i]) begin
      run_one(vals[i]);
      check("bound_inc_c", cnt[C_INC_C], (vals[i] > 9) ? 5 : 0);
    end

    // Counter mismatch at second CHECK
    inject = 1'b1;
    run_one(3);
    inject = 1'b0;
    repeat (3) step();
    check("err_sticky", int'(err_o), CHK_EN ? 1 : 0);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    #1 check("err_clear", int'(err_o), 0);
    drain();

    // Reset during PLUS6 aborts without done
    plan_mode = 12;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    n = 0;
    while (!(q.size() > 0 && q[0].code == C_PLUS6) && n < 50) begin
      step();
      n++;
    end
    #1 check("in_plus6", int'(state_plus_6_c), 1);
    rst = 1'b1;
    #1 check("rst_plus6",
             int'({state_load, state_sum, state_inc_c, state_plus_6_c, state_inc_s, busy, done, idx_o, err_o}), 0);
    q.delete(); idx_m = 0; err_m = 0;
    step();
    rst = 1'b0;
    dc0 = done_cnt;
    repeat (30) step();
    check("no_done_after_rst", done_cnt - dc0, 0);

    // Start held high: back-to-back runs one IDLE apart
    plan_mode = 3;
    dc0 = done_cnt;
    last_done = -1;
    start_req = 1'b1;
    repeat (60) step();
    start_req = 1'b0;
    drain();
    check("b2b_done_cnt", done_cnt - dc0, 4);
    check("b2b_gap", done_gap, 18);

    // Random digits with random start requests
    plan_mode = -1;
    for (int i = 0; i < 400; i++) begin
      start_req = ($urandom_range(0, 3) == 0);
      step();
    end
    start_req = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
